// File: rtl/mips_boot_mem_pkg.sv
// Shared types and constants for the MIPS boot memory slice.
package mips_mem_pkg;

    typedef enum logic {LOAD, RUN} bootstate_t;

    // Address of the memory-mapped output register (top byte of RAM);
    // only decoded when MIPS_BOOT_MEM_MMIO_EN is defined.
    localparam logic [5:0] MMIO_ADR = 6'h3F;

endpackage

// File: rtl/mips_boot_mem_if.sv
// Core <-> boot memory bus: address/strobes/store data out of the core,
// read data and core reset back into it.
interface mips_boot_mem_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic             cpu_reset;
    logic [AW-1:0]    cpu_adr;
    logic             cpu_memread;
    logic             cpu_memwrite;
    logic [WIDTH-1:0] cpu_writedata;
    logic [WIDTH-1:0] cpu_memdata;

    // Core side.
    modport master (
        output cpu_adr, cpu_memread, cpu_memwrite, cpu_writedata,
        input  cpu_memdata, cpu_reset
    );

    // Memory side.
    modport slave (
        input  cpu_adr, cpu_memread, cpu_memwrite, cpu_writedata,
        output cpu_memdata, cpu_reset
    );
endinterface

// File: rtl/mips_boot_mem_sync_rise.sv
// Two-flop synchronizer plus rising-edge detector for a slow async pin
// strobe. One single-cycle pulse per rising edge of async_in, whatever
// its high time. Flops reset to 0 so an in-flight edge is dropped.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);
    // sync_pipe[1..2] are the metastability stages, [3] is the edge history.
    logic [3:1] sync_pipe;

    // Shift the pin through the synchronizer and history stage.
    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[2:1], async_in};
    end

    assign pulse = sync_pipe[2] & ~sync_pipe[3];
endmodule

// File: rtl/mips_boot_mem.sv
// Byte-wide unified I/D memory for the 8-bit multicycle MIPS core with a
// pin-fed program loader. Holds the core in reset while bytes are loaded,
// then behaves as a zero-wait-state RAM with a combinational read port.
// Optional feature: define MIPS_BOOT_MEM_MMIO_EN to make core writes to the
// top byte also update mmio_out.
module mips_boot_mem
    import mips_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    mips_boot_mem_if.slave   bus,
    output logic [AW:0]      load_count,
    output logic             running,
    output logic [WIDTH-1:0] mmio_out
);
    localparam int DEPTH = 2 ** AW;

    bootstate_t       state, state_nxt;
    logic             capture;
    logic             load_we, cpu_we;
    logic [WIDTH-1:0] ram [DEPTH];

    sync_rise u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (load_valid),
        .pulse    (capture)
    );

    assign load_we = (state == LOAD) && capture;
    assign cpu_we  = (state == RUN) && bus.cpu_memwrite;

    // State register; reset always returns to LOAD.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Leave LOAD after the flagged last byte or when the RAM is full.
    always_comb begin
        state_nxt = state;
        if (load_we && (load_last || load_count == (AW+1)'(DEPTH - 1)))
            state_nxt = RUN;
    end

    // Core reset and running flag decode straight from the state flop,
    // so both change on the edge that enters RUN.
    always_comb begin
        bus.cpu_reset = (state == LOAD);
        running       = (state == RUN);
    end

    // Loaded-byte counter; stops at DEPTH because LOAD ends on the last slot.
    always_ff @(posedge clk) begin
        if (reset)        load_count <= '0;
        else if (load_we) load_count <= load_count + (AW+1)'(1);
    end

    // Single RAM write port shared by loader (LOAD) and core (RUN);
    // contents survive reset, but reset blocks any write on its edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_we)     ram[load_count[AW-1:0]] <= load_data;
            else if (cpu_we) ram[bus.cpu_adr]        <= bus.cpu_writedata;
        end
    end

    // Combinational read: the core latches memdata at the end of this cycle,
    // and a same-cycle write shows the old contents.
    always_comb begin
        bus.cpu_memdata = '0;
        if (state == RUN && bus.cpu_memread)
            bus.cpu_memdata = ram[bus.cpu_adr];
    end

`ifdef MIPS_BOOT_MEM_MMIO_EN
    // Memory-mapped output register shadowing core writes to the top byte.
    always_ff @(posedge clk) begin
        if (reset)
            mmio_out <= '0;
        else if (cpu_we && bus.cpu_adr == AW'(MMIO_ADR))
            mmio_out <= bus.cpu_writedata;
    end
`else
    assign mmio_out = '0;
`endif
endmodule

// File: tb/tb_mips_boot_mem.sv
// Self-checking bench for mips_boot_mem: directed load scenarios plus
// randomized RUN traffic checked against a behavioural memory model.
module tb_mips_boot_mem;
    localparam int WIDTH = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic [AW:0]      load_count;
    logic             running;
    logic [WIDTH-1:0] mmio_out;

    mips_boot_mem_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mips_boot_mem #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .bus        (bus.slave),
        .load_count (load_count),
        .running    (running),
        .mmio_out   (mmio_out)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, bytes loaded, run flag, output register.
    logic [7:0] ram_m [DEPTH];
    int         count_m;
    bit         run_m;
    logic [7:0] mmio_m;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A byte accepted by the loader, as seen by the model.
    task automatic model_cap(input logic [7:0] d, input bit last);
        if (!run_m) begin
            ram_m[count_m % DEPTH] = d;
            count_m++;
            if (last || count_m == DEPTH) run_m = 1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"},   32'(load_count),    32'(count_m));
        check({tag, ".running"}, 32'(running),       32'(run_m));
        check({tag, ".cpu_rst"}, 32'(bus.cpu_reset), 32'(!run_m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; load_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        count_m = 0; run_m = 0; mmio_m = 8'h00;
    endtask

    task automatic strobe(input logic [7:0] d, input bit last, input int hold);
        @(negedge clk);
        load_data = d; load_last = last; load_valid = 1;
        repeat (hold) @(negedge clk);
        load_valid = 0;
        repeat (4) @(negedge clk);
        model_cap(d, last);
    endtask

    // One core bus cycle: check the combinational read, then the model
    // absorbs the write that the next edge performs.
    task automatic cpu_op(input logic [5:0] adr, input bit rd, input bit wr,
                          input logic [7:0] d, input string tag);
        @(negedge clk);
        bus.cpu_adr = adr; bus.cpu_memread = rd; bus.cpu_memwrite = wr;
        bus.cpu_writedata = d;
        #1;
        check({tag, ".rdata"}, 32'(bus.cpu_memdata), 32'((run_m && rd) ? ram_m[adr] : 8'h00));
        check({tag, ".mmio"},  32'(mmio_out), 32'(mmio_m));
        if (run_m && wr) begin
            ram_m[adr] = d;
`ifdef MIPS_BOOT_MEM_MMIO_EN
            if (adr == 6'h3F) mmio_m = d;
`endif
        end
    endtask

    task automatic cpu_idle();
        @(negedge clk);
        bus.cpu_memread = 0; bus.cpu_memwrite = 0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] ram0;
        reset = 1; load_valid = 0; load_data = 0; load_last = 0;
        bus.cpu_adr = 0; bus.cpu_memread = 1; bus.cpu_memwrite = 0; bus.cpu_writedata = 0;
        count_m = 0; run_m = 0; mmio_m = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        // Reset state, with a read request pending.
        check_status("rst");
        check("rst.mmio",  32'(mmio_out), 32'h0);
        check("rst.rdata", 32'(bus.cpu_memdata), 32'h0);
        bus.cpu_memread = 0;

        // Four-byte image, last byte cycle-checked.
        strobe(8'h11, 0, $urandom_range(1, 4)); check_status("img1");
        strobe(8'h22, 0, $urandom_range(1, 4)); check_status("img2");
        strobe(8'h33, 0, $urandom_range(1, 4)); check_status("img3");
        @(negedge clk);
        load_data = 8'h44; load_last = 1; load_valid = 1;
        @(negedge clk); check("edge1.cpu_rst", 32'(bus.cpu_reset), 32'h1);
        @(negedge clk); check("edge2.cpu_rst", 32'(bus.cpu_reset), 32'h1);
        @(negedge clk); check("edge3.cpu_rst", 32'(bus.cpu_reset), 32'h0);
        check("edge3.running", 32'(running), 32'h1);
        load_valid = 0;
        model_cap(8'h44, 1);
        repeat (4) @(negedge clk);
        check_status("img4");
        for (int a = 0; a < 4; a++) cpu_op(6'(a), 1, 0, 8'h00, "rd_img");
        cpu_op(6'h02, 1, 1, 8'h5A, "wr_5a");
        cpu_op(6'h02, 1, 0, 8'h00, "rd_5a");
        cpu_op(6'h3F, 0, 1, 8'h7E, "wr_mmio");
        cpu_op(6'h3F, 1, 0, 8'h00, "rd_mmio");
        cpu_idle();

        // Reset while running: RAM is kept, status restarts.
        do_reset();
        #1;
        check_status("rrst");
        check("rrst.mmio", 32'(mmio_out), 32'h0);
        strobe(8'h99, 1, 2);
        check_status("reload");
        for (int a = 0; a < 4; a++) cpu_op(6'(a), 1, 0, 8'h00, "retain");
        cpu_idle();

        // Strobe caught in the synchronizer when reset hits is dropped.
        do_reset();
        @(negedge clk);
        load_data = 8'hC3; load_last = 1; load_valid = 1;
        @(negedge clk);
        reset = 1; load_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (6) @(negedge clk);
        check_status("inflight");

        // Long strobe produces one capture only.
        strobe(8'hA5, 0, 20);
        check_status("long");

        // Full 64-byte image without load_last; core writes during LOAD ignored.
        do_reset();
        bus.cpu_adr = 6'h05; bus.cpu_writedata = 8'hEE;
        bus.cpu_memread = 1; bus.cpu_memwrite = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                bus.cpu_memwrite = 0; bus.cpu_memread = 0;
            end
            strobe(8'($urandom), 0, $urandom_range(1, 3));
            if (i == 10) check("load.rdata", 32'(bus.cpu_memdata), 32'h0);
            if (i == 31 || i == DEPTH - 2) check_status("full_mid");
        end
        check_status("full");
        cpu_op(6'h05, 1, 0, 8'h00, "ign_wr");
        cpu_idle();
        ram0 = ram_m[0];
        strobe(8'hFF, 1, 2);
        check_status("over");
        cpu_op(6'h00, 1, 0, 8'h00, "over_ram0");
        check("over.model_ram0", 32'(ram_m[0]), 32'(ram0));

        // Random RUN traffic.
        for (int i = 0; i < 80; i++) begin
            d = 8'($urandom);
            cpu_op((i % 8 == 0) ? 6'h3F : 6'($urandom), 1'($urandom), 1'($urandom), d, "rand");
        end
        cpu_op(6'h3F, 1, 0, 8'h00, "rand_end");
        cpu_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
